if_else_select_pipe: RTL and testbench

//  N-channel, parametrised successor of the single-segment if/else combiner.
//  Per channel: computes an IF-branch and an ELSE-branch result, evaluates a condition

---
 rtl/if_else_select_pipe_pkg.sv | 12 +
 rtl/if_else_select_pipe_lane.sv | 50 +++++
 rtl/if_else_select_pipe.sv | 124 ++++++++++++
 tb/tb_if_else_select_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_else_select_pipe_pkg.sv
// Shared constants and helpers for the if/else select pipeline.
// sat_inc is width-agnostic: callers widen to 64 bits and cast the result back.
package if_else_pkg;

  localparam int COND_BIT    = 0;
  localparam int COND_THRESH = 1;

  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 64'd1;
  endfunction

endpackage

// File: rtl/if_else_select_pipe_lane.sv
// One channel: IF/ELSE arithmetic, branch select, and the per-channel data stages.
// Stage valids live in the top; this lane only follows the shared advance strobe.
module if_else_lane
  import if_else_pkg::*;
#(
  parameter int W          = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance_i,
  input  logic         cond_i,
  input  logic [W-1:0] opnd_i,
  input  logic [W-1:0] if_opnd_i,
  input  logic [W-1:0] else_opnd_i,
  output logic [W-1:0] seg_o,
  output logic         sel_o
);

  logic [W-1:0] if_res;
  logic [W-1:0] else_res;
  logic [W-1:0] seg_d;
  logic [W-1:0] data_q [PIPE_DEPTH];
  logic         sel_q  [PIPE_DEPTH];

  assign if_res   = if_opnd_i + opnd_i;
  assign else_res = else_opnd_i - opnd_i;
  assign seg_d    = cond_i ? if_res : else_res;

  // Bubbles load whatever is on the inputs; the valid chain in the top masks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= 1'b0;
      end
    end else if (advance_i) begin
      data_q[0] <= seg_d;
      sel_q[0]  <= cond_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        sel_q[i]  <= sel_q[i-1];
      end
    end
  end

  assign seg_o = data_q[PIPE_DEPTH-1];
  assign sel_o = sel_q[PIPE_DEPTH-1];

endmodule

// File: rtl/if_else_select_pipe.sv
// N-channel if/else select pipeline with valid/ready handshake and global stall.
// Owns the valid shift chain, the handshake and the saturating IF-taken counters.
module if_else_select_pipe
  import if_else_pkg::*;
#(
  parameter int             W          = 32,
  parameter int             N          = 8,
  parameter int             PIPE_DEPTH = 2,
  parameter int             COND_MODE  = COND_BIT,
  parameter logic [W-1:0]   THRESH     = '0,
  parameter int             CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       input_bit,
  input  logic [N*W-1:0]     array_ref_wire,
  input  logic [N*W-1:0]     array_ref_m_wire,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W-1:0]     segment_combine,
  output logic [N-1:0]       segment_sel,
  output logic [N*CNT_W-1:0] if_count,
  input  logic               clr_count
);

  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("if_else_select_pipe: PIPE_DEPTH must be >= 1");
  end
  if (COND_MODE != COND_BIT && COND_MODE != COND_THRESH) begin : g_bad_mode
    $error("if_else_select_pipe: COND_MODE must be 0 or 1");
  end
  if (COND_MODE == COND_BIT && N > W) begin : g_bad_width
    $error("if_else_select_pipe: per-bit condition needs N <= W");
  end
  if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt
    $error("if_else_select_pipe: CNT_W must be in 1..64");
  end

  localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? {64{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

  logic         advance;
  logic         xfer;
  logic [N-1:0] cond;
  logic         valid_q [PIPE_DEPTH];

  assign out_valid = valid_q[PIPE_DEPTH-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  genvar gi;

  if (COND_MODE == COND_THRESH) begin : g_cond_thresh
    logic thresh_hit;
    assign thresh_hit = (input_bit >= THRESH);
    assign cond       = {N{thresh_hit}};
  end else begin : g_cond_bit
    for (gi = 0; gi < N; gi++) begin : g_bit
      if (gi < W) begin : g_in_range
        assign cond[gi] = input_bit[gi];
      end else begin : g_out_range
        assign cond[gi] = 1'b0;
      end
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_lane
    if_else_lane #(
      .W          (W),
      .PIPE_DEPTH (PIPE_DEPTH)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .advance_i   (advance),
      .cond_i      (cond[gi]),
      .opnd_i      (input_bit),
      .if_opnd_i   (array_ref_wire[gi*W +: W]),
      .else_opnd_i (array_ref_m_wire[gi*W +: W]),
      .seg_o       (segment_combine[gi*W +: W]),
      .sel_o       (segment_sel[gi])
    );
  end

  // Counting happens on the output transfer, so stalled beats are counted once.
  for (gi = 0; gi < N; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
        cnt_d = '0;
      end else if (xfer && segment_sel[gi]) begin
        cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_MAX));
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign if_count[gi*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_if_else_select_pipe.sv
// Bench for if_else_select_pipe: per-bit mode (CNT_W=2) and threshold mode instances.
// Expected beats are queued on acceptance and compared when the DUT transfers them.
module tb_if_else_select_pipe;

  localparam int W   = 32;
  localparam int N   = 8;
  localparam int NW  = N * W;
  localparam int CWA = 2;
  localparam int CWB = 16;

  logic clk = 1'b0;
  logic reset;

  logic             in_valid_a, in_ready_a, out_valid_a, out_ready_a, clr_a;
  logic [W-1:0]     bit_a;
  logic [NW-1:0]    ref_a, refm_a, seg_a;
  logic [N-1:0]     sel_a;
  logic [N*CWA-1:0] cnt_a;

  logic             in_valid_b, in_ready_b, out_valid_b, out_ready_b, clr_b;
  logic [W-1:0]     bit_b;
  logic [NW-1:0]    ref_b, refm_b, seg_b;
  logic [N-1:0]     sel_b;
  logic [N*CWB-1:0] cnt_b;

  typedef struct packed {
    logic [NW-1:0] data;
    logic [N-1:0]  sel;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned cnt_m [N];
  int          passed = 0;
  int          total  = 0;
  int          n_in   = 0;
  int          n_out  = 0;
  logic [NW-1:0] held;
  logic [NW-1:0] exp_b;

  always #5 clk = ~clk;

  if_else_select_pipe #(
    .W(W), .N(N), .PIPE_DEPTH(2), .COND_MODE(0), .THRESH(32'd0), .CNT_W(CWA)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .input_bit(bit_a), .array_ref_wire(ref_a), .array_ref_m_wire(refm_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .segment_combine(seg_a),
    .segment_sel(sel_a), .if_count(cnt_a), .clr_count(clr_a)
  );

  if_else_select_pipe #(
    .W(W), .N(N), .PIPE_DEPTH(2), .COND_MODE(1), .THRESH(32'd100), .CNT_W(CWB)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .input_bit(bit_b), .array_ref_wire(ref_b), .array_ref_m_wire(refm_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .segment_combine(seg_b),
    .segment_sel(sel_b), .if_count(cnt_b), .clr_count(clr_b)
  );

  task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic beat_t model_a(input logic [W-1:0] b, input logic [NW-1:0] r,
                                    input logic [NW-1:0] rm);
    beat_t e;
    for (int c = 0; c < N; c++) begin
      e.sel[c]         = b[c];
      e.data[c*W +: W] = b[c] ? (r[c*W +: W] + b) : (rm[c*W +: W] - b);
    end
    return e;
  endfunction

  function automatic logic [N*CWA-1:0] cnt_pack();
    logic [N*CWA-1:0] p;
    for (int c = 0; c < N; c++) p[c*CWA +: CWA] = CWA'(cnt_m[c]);
    return p;
  endfunction

  task automatic drive_rand();
    bit_a = $urandom;
    for (int c = 0; c < N; c++) begin
      ref_a[c*W +: W]  = $urandom;
      refm_a[c*W +: W] = $urandom;
    end
  endtask

  // One clock of dut_a: sample handshake before the edge, update scoreboard, check counters after.
  task automatic step();
    beat_t e;
    logic  acc, xfer;
    #1;
    acc  = in_valid_a && in_ready_a;
    xfer = out_valid_a && out_ready_a;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", NW'(out_valid_a), '0);
      end else begin
        e = exp_q.pop_front();
        check("segment", seg_a, e.data);
        check("sel", NW'(sel_a), NW'(e.sel));
        n_out++;
        if (!clr_a)
          for (int c = 0; c < N; c++)
            if (e.sel[c] && cnt_m[c] < 3) cnt_m[c]++;
      end
    end
    if (clr_a) for (int c = 0; c < N; c++) cnt_m[c] = 0;
    if (acc) begin
      exp_q.push_back(model_a(bit_a, ref_a, refm_a));
      n_in++;
    end
    @(posedge clk);
    @(negedge clk);
    check("if_count", NW'(cnt_a), NW'(cnt_pack()));
  endtask

  initial begin
    reset = 1'b1;
    in_valid_a = 0; out_ready_a = 1; clr_a = 0; bit_a = '0; ref_a = '0; refm_a = '0;
    in_valid_b = 0; out_ready_b = 1; clr_b = 0; bit_b = '0; ref_b = '0; refm_b = '0;
    for (int c = 0; c < N; c++) cnt_m[c] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", NW'(out_valid_a), '0);
    check("rst_in_ready", NW'(in_ready_a), NW'(1));
    check("rst_segment", seg_a, '0);
    check("rst_sel", NW'(sel_a), '0);
    check("rst_count", NW'(cnt_a), '0);
    check("rst_out_valid_b", NW'(out_valid_b), '0);

    // 1: single beat, latency of two cycles
    @(negedge clk);
    bit_a = 32'h5;
    ref_a = {N{32'd10}};
    refm_a = {N{32'd10}};
    in_valid_a = 1;
    step();
    in_valid_a = 0;
    check("lat_early", NW'(out_valid_a), '0);
    step();
    check("lat_valid", NW'(out_valid_a), NW'(1));
    check("t1_ch0", NW'(seg_a[0 +: W]), NW'(32'd15));
    check("t1_ch1", NW'(seg_a[W +: W]), NW'(32'd5));
    check("t1_ch2", NW'(seg_a[2*W +: W]), NW'(32'd15));
    check("t1_sel", NW'(sel_a), NW'(8'b0000_0101));
    step();

    // 2: 16 back-to-back beats at full rate
    n_in = 0; n_out = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid_a = 1;
      drive_rand();
      #1;
      check("stream_in_ready", NW'(in_ready_a), NW'(1));
      step();
    end
    in_valid_a = 0;
    repeat (3) step();
    check("stream_out_count", NW'(n_out), NW'(16));
    check("stream_in_count", NW'(n_in), NW'(16));

    // 3: five-cycle downstream stall mid-stream
    n_in = 0; n_out = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid_a  = 1;
      out_ready_a = !(i >= 6 && i < 11);
      drive_rand();
      #1;
      if (i >= 6 && i < 11) begin
        if (i == 6) held = seg_a;
        check("stall_hold", seg_a, held);
        check("stall_valid", NW'(out_valid_a), NW'(1));
        check("stall_in_ready", NW'(in_ready_a), '0);
      end
      step();
    end
    in_valid_a = 0;
    out_ready_a = 1;
    repeat (3) step();
    check("stall_no_loss", NW'(n_out), NW'(n_in));
    check("stall_queue_empty", NW'(exp_q.size()), '0);

    // 4: threshold mode, IF at 100 and wrapping ELSE at 99
    for (int c = 0; c < N; c++) ref_b[c*W +: W] = 32'd1000 + 32'(c);
    refm_b = '0;
    bit_b = 32'd100;
    in_valid_b = 1;
    @(posedge clk); @(negedge clk);
    bit_b = 32'd99;
    @(posedge clk); @(negedge clk);
    in_valid_b = 0;
    #1;
    for (int c = 0; c < N; c++) exp_b[c*W +: W] = 32'd1100 + 32'(c);
    check("thr_valid1", NW'(out_valid_b), NW'(1));
    check("thr_if_data", seg_b, exp_b);
    check("thr_if_sel", NW'(sel_b), NW'(8'hFF));
    @(posedge clk); @(negedge clk);
    #1;
    check("thr_valid2", NW'(out_valid_b), NW'(1));
    check("thr_else_data", seg_b, {N{32'hFFFF_FF9D}});
    check("thr_else_sel", NW'(sel_b), '0);
    @(posedge clk); @(negedge clk);
    check("thr_count", NW'(cnt_b), NW'({N{16'd1}}));

    // 5: saturation at 3 with CNT_W=2, then clear racing a transfer
    clr_a = 1;
    step();
    clr_a = 0;
    ref_a = '0; refm_a = '0; bit_a = 32'h1;
    in_valid_a = 1;
    repeat (5) step();
    in_valid_a = 0;
    repeat (3) step();
    check("sat_ch0", NW'(cnt_a[0 +: CWA]), NW'(2'd3));
    in_valid_a = 1;
    step();
    in_valid_a = 0;
    step();
    clr_a = 1;
    #1;
    check("clr_race_valid", NW'(out_valid_a), NW'(1));
    step();
    clr_a = 0;
    check("clr_race_ch0", NW'(cnt_a[0 +: CWA]), '0);
    in_valid_a = 1;
    step();
    in_valid_a = 0;
    repeat (3) step();
    check("count_after_clr", NW'(cnt_a[0 +: CWA]), NW'(2'd1));

    // 6: reset with two beats in flight
    in_valid_a = 1;
    bit_a = 32'h3;
    step();
    step();
    in_valid_a = 0;
    reset = 1;
    @(posedge clk); @(negedge clk);
    #1;
    check("mid_rst_valid", NW'(out_valid_a), '0);
    check("mid_rst_count", NW'(cnt_a), '0);
    check("mid_rst_segment", seg_a, '0);
    reset = 0;
    exp_q.delete();
    for (int c = 0; c < N; c++) cnt_m[c] = 0;
    #1;
    check("mid_rst_in_ready", NW'(in_ready_a), NW'(1));
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_quiet", NW'(out_valid_a), '0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
